rule_stream_arbiter: RTL and testbench

- Packet-granular round-robin arbiter.
- Shares one 512-bit rule-delivery stream among NUM_IN independent rule sources (e.g. host DMA, reload engine).
- Feeds the single downstream rule depacker input (Avalon-ST style: sop/eop/empty/valid/ready).
- Once granted, a source owns the output until its eop beat is accepted. Rule packets are never interleaved.

---
 rtl/rule_stream_arbiter.sv | 144 ++++++++++++++
 tb/tb_rule_stream_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_stream_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_IN Avalon-ST rule sources onto one stream.
// A granted source owns the output until its eop beat is accepted; each packet costs one IDLE cycle.
module rule_stream_arbiter #(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned DW     = 512,
   parameter int unsigned EW     = 6,
   parameter int unsigned SW     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_IN-1:0]    in_sop,
   input  logic [NUM_IN-1:0]    in_eop,
   input  logic [NUM_IN*EW-1:0] in_empty,
   input  logic [NUM_IN-1:0]    in_valid,
   input  logic [NUM_IN*DW-1:0] in_data,
   output logic [NUM_IN-1:0]    in_ready,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [EW-1:0]        out_empty,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   input  logic                 out_ready,
   output logic [SW-1:0]        out_src,
   output logic [31:0]          pkt_cnt,
   output logic                 proto_err
);

   if (SW != $clog2(NUM_IN)) begin : g_bad_sw
      $error("rule_stream_arbiter: SW must equal clog2(NUM_IN)");
   end

   typedef enum logic {
      IDLE,
      LOCK
   } state_e;

   state_e        state_q;
   logic [SW-1:0] grant_q;
   logic [SW-1:0] last_q;
   logic [31:0]   pkt_cnt_q;
   logic          proto_err_q;
   logic          first_q;

   logic [SW-1:0] grant_d;
   logic          any_req;
   logic          sel_sop;
   logic          sel_eop;
   logic          sel_valid;
   logic [EW-1:0] sel_empty;
   logic [DW-1:0] sel_data;
   logic          lock;
   logic          xfer;

   // Round-robin search starts just after the last source that completed a packet.
   always_comb begin
      int unsigned idx;
      logic        found;
      grant_d = '0;
      found   = 1'b0;
      idx     = 0;
      any_req = |in_valid;
      for (int unsigned k = 1; k <= NUM_IN; k++) begin
         idx = (32'(last_q) + k) % NUM_IN;
         if (!found && in_valid[idx]) begin
            found   = 1'b1;
            grant_d = SW'(idx);
         end
      end
   end

   always_comb begin
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_valid = 1'b0;
      sel_empty = '0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (SW'(i) == grant_q) begin
            sel_sop   = in_sop[i];
            sel_eop   = in_eop[i];
            sel_valid = in_valid[i];
            sel_empty = in_empty[i*EW +: EW];
            sel_data  = in_data[i*DW +: DW];
         end
      end
   end

   // Gated by rst so no handshake can complete while reset is held.
   assign lock      = (state_q == LOCK) && !rst;
   assign out_valid = lock & sel_valid;
   assign out_sop   = lock & sel_sop;
   assign out_eop   = lock & sel_eop;
   assign out_empty = lock ? sel_empty : '0;
   assign out_data  = lock ? sel_data : '0;
   assign xfer      = out_valid & out_ready;

   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         in_ready[i] = lock && (SW'(i) == grant_q) && out_ready;
      end
   end

   assign out_src   = grant_q;
   assign pkt_cnt   = pkt_cnt_q;
   assign proto_err = proto_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= SW'(NUM_IN - 1);
         pkt_cnt_q   <= '0;
         proto_err_q <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q <= grant_d;
                  first_q <= 1'b1;
                  state_q <= LOCK;
               end
            end
            LOCK: begin
               if (xfer) begin
                  first_q <= 1'b0;
                  // sop must appear exactly on the first accepted beat of a grant.
                  if (first_q != out_sop) begin
                     proto_err_q <= 1'b1;
                  end
                  if (out_eop) begin
                     state_q   <= IDLE;
                     last_q    <= grant_q;
                     pkt_cnt_q <= pkt_cnt_q + 32'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// Directed bench for rule_stream_arbiter: 4 sources, 512-bit beats, hand-computed expectations.
module tb_rule_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 512;
   localparam int EW = 6;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    in_sop, in_eop, in_valid, in_ready;
   logic [N*EW-1:0] in_empty;
   logic [N*DW-1:0] in_data;
   logic            out_sop, out_eop, out_valid, out_ready;
   logic [EW-1:0]   out_empty;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic [31:0]     pkt_cnt;
   logic            proto_err;

   int ncmp = 0;
   int nerr = 0;

   rule_stream_arbiter #(.NUM_IN(N), .DW(DW), .EW(EW), .SW(SW)) dut (
      .clk(clk), .rst(rst),
      .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .out_src(out_src),
      .pkt_cnt(pkt_cnt), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int s, input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(s * 256 + k);
      return {16{w}};
   endfunction

   task automatic set_src(input int s, input logic v, input logic sop, input logic eop,
                          input logic [EW-1:0] emp, input logic [DW-1:0] d);
      in_valid[s]          = v;
      in_sop[s]            = sop;
      in_eop[s]            = eop;
      in_empty[s*EW +: EW] = emp;
      in_data[s*DW +: DW]  = d;
   endtask

   task automatic clear_all();
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      in_empty = '0;
      in_data  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      out_ready = 1'b1;
      clear_all();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = '1;
      in_sop    = '1;
      tick();
      @(negedge clk);
      ncmp++; if (in_ready !== 4'b0000) begin $display("FAIL reset_in_ready: got %b want 0000", in_ready); nerr++; end
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); nerr++; end
      ncmp++; if (pkt_cnt !== 32'd0) begin $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); nerr++; end
      ncmp++; if (proto_err !== 1'b0) begin $display("FAIL reset_proto_err: got %b want 0", proto_err); nerr++; end
      ncmp++; if (out_src !== 2'd0) begin $display("FAIL reset_out_src: got %0d want 0", out_src); nerr++; end
      tick();
      rst = 1'b0;
      clear_all();
   endtask

   task automatic test_single();
      do_reset();
      set_src(1, 1'b1, 1'b1, 1'b0, 6'd0, mk(1, 0));
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL single_bubble: got %b want 0", out_valid); nerr++; end
      for (int b = 0; b < 3; b++) begin
         tick();
         set_src(1, 1'b1, b == 0, b == 2, (b == 2) ? 6'd4 : 6'd0, mk(1, b));
         @(negedge clk);
         ncmp++; if (out_valid !== 1'b1) begin $display("FAIL single_valid b%0d: got %b want 1", b, out_valid); nerr++; end
         ncmp++; if (out_src !== 2'd1) begin $display("FAIL single_src b%0d: got %0d want 1", b, out_src); nerr++; end
         ncmp++; if (out_data !== mk(1, b)) begin $display("FAIL single_data b%0d: got %0h want %0h", b, out_data, mk(1, b)); nerr++; end
         ncmp++; if (in_ready !== 4'b0010) begin $display("FAIL single_ready b%0d: got %b want 0010", b, in_ready); nerr++; end
         if (b == 2) begin
            ncmp++; if (out_empty !== 6'd4) begin $display("FAIL single_empty: got %0d want 4", out_empty); nerr++; end
            ncmp++; if (out_eop !== 1'b1) begin $display("FAIL single_eop: got %b want 1", out_eop); nerr++; end
         end
      end
      tick();
      clear_all();
      @(negedge clk);
      ncmp++; if (pkt_cnt !== 32'd1) begin $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); nerr++; end
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL single_idle: got %b want 0", out_valid); nerr++; end
   endtask

   task automatic test_round_robin();
      int bi[N];
      logic [N-1:0] hs;
      int ph, src, k;
      do_reset();
      for (int s = 0; s < N; s++) bi[s] = 0;
      for (int c = 0; c < 15; c++) begin
         for (int s = 0; s < N; s++)
            set_src(s, 1'b1, (bi[s] % 2) == 0, (bi[s] % 2) == 1, 6'd0, mk(s, bi[s]));
         @(negedge clk);
         ph  = c % 3;
         src = (c / 3) % 4;
         k   = ((c / 3) / 4) * 2 + ph - 1;
         if (ph == 0) begin
            ncmp++; if (out_valid !== 1'b0) begin $display("FAIL rr_bubble c%0d: got %b want 0", c, out_valid); nerr++; end
         end else begin
            ncmp++; if (out_valid !== 1'b1) begin $display("FAIL rr_valid c%0d: got %b want 1", c, out_valid); nerr++; end
            ncmp++; if (out_src !== SW'(src)) begin $display("FAIL rr_src c%0d: got %0d want %0d", c, out_src, src); nerr++; end
            ncmp++; if (out_data !== mk(src, k)) begin $display("FAIL rr_data c%0d: got %0h want %0h", c, out_data, mk(src, k)); nerr++; end
            ncmp++; if (out_sop !== (ph == 1)) begin $display("FAIL rr_sop c%0d: got %b want %b", c, out_sop, ph == 1); nerr++; end
            ncmp++; if (in_ready !== (4'b0001 << src)) begin $display("FAIL rr_ready c%0d: got %b want %b", c, in_ready, 4'b0001 << src); nerr++; end
         end
         hs = in_ready & in_valid;
         tick();
         for (int s = 0; s < N; s++) if (hs[s]) bi[s]++;
      end
      clear_all();
      @(negedge clk);
      ncmp++; if (pkt_cnt !== 32'd5) begin $display("FAIL rr_pkt_cnt: got %0d want 5", pkt_cnt); nerr++; end
   endtask

   task automatic test_backpressure();
      int r_t[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
      int v_t[9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
      int k_t[9] = '{0, 1, 1, 1, 1, 2, 2, 3, 3};
      int k;
      logic hs;
      do_reset();
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd0, mk(2, 0));
      @(negedge clk);
      tick();
      set_src(0, 1'b1, 1'b1, 1'b1, 6'd0, mk(0, 0));
      set_src(3, 1'b1, 1'b1, 1'b1, 6'd0, mk(3, 0));
      k = 0;
      for (int c = 0; c < 9; c++) begin
         out_ready = (r_t[c] != 0);
         set_src(2, v_t[c] != 0, k == 0, k == 3, 6'd0, mk(2, k));
         @(negedge clk);
         ncmp++; if (out_valid !== (v_t[c] != 0)) begin $display("FAIL bp_valid c%0d: got %b want %0d", c, out_valid, v_t[c]); nerr++; end
         ncmp++; if (in_ready !== ((r_t[c] != 0) ? 4'b0100 : 4'b0000)) begin $display("FAIL bp_ready c%0d: got %b want %0d on bit2 only", c, in_ready, r_t[c]); nerr++; end
         ncmp++; if (out_src !== 2'd2) begin $display("FAIL bp_src c%0d: got %0d want 2", c, out_src); nerr++; end
         if (v_t[c] != 0) begin
            ncmp++; if (out_data !== mk(2, k_t[c])) begin $display("FAIL bp_data c%0d: got %0h want %0h", c, out_data, mk(2, k_t[c])); nerr++; end
         end
         hs = in_ready[2] & in_valid[2];
         tick();
         if (hs) k++;
      end
      set_src(2, 1'b0, 1'b0, 1'b0, 6'd0, '0);
      out_ready = 1'b1;
      @(negedge clk);
      ncmp++; if (k !== 4) begin $display("FAIL bp_beats: got %0d want 4", k); nerr++; end
      ncmp++; if (pkt_cnt !== 32'd1) begin $display("FAIL bp_pkt_cnt: got %0d want 1", pkt_cnt); nerr++; end
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL bp_idle: got %b want 0", out_valid); nerr++; end
      tick();
      @(negedge clk);
      ncmp++; if (out_src !== 2'd3) begin $display("FAIL bp_next_src: got %0d want 3", out_src); nerr++; end
      ncmp++; if (out_data !== mk(3, 0)) begin $display("FAIL bp_next_data: got %0h want %0h", out_data, mk(3, 0)); nerr++; end
      tick();
      clear_all();
   endtask

   task automatic test_proto_err();
      do_reset();
      set_src(0, 1'b1, 1'b0, 1'b0, 6'd0, mk(0, 0));
      @(negedge clk);
      tick();
      @(negedge clk);
      ncmp++; if (out_data !== mk(0, 0)) begin $display("FAIL pe_fwd0: got %0h want %0h", out_data, mk(0, 0)); nerr++; end
      ncmp++; if (proto_err !== 1'b0) begin $display("FAIL pe_pre: got %b want 0", proto_err); nerr++; end
      tick();
      set_src(0, 1'b1, 1'b0, 1'b1, 6'd0, mk(0, 1));
      @(negedge clk);
      ncmp++; if (proto_err !== 1'b1) begin $display("FAIL pe_nosop: got %b want 1", proto_err); nerr++; end
      ncmp++; if (out_data !== mk(0, 1)) begin $display("FAIL pe_fwd1: got %0h want %0h", out_data, mk(0, 1)); nerr++; end
      tick();
      clear_all();
      set_src(1, 1'b1, 1'b1, 1'b1, 6'd0, mk(1, 0));
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      clear_all();
      @(negedge clk);
      ncmp++; if (proto_err !== 1'b1) begin $display("FAIL pe_sticky: got %b want 1", proto_err); nerr++; end
      ncmp++; if (pkt_cnt !== 32'd2) begin $display("FAIL pe_pkt_cnt: got %0d want 2", pkt_cnt); nerr++; end
      do_reset();
      @(negedge clk);
      ncmp++; if (proto_err !== 1'b0) begin $display("FAIL pe_cleared: got %b want 0", proto_err); nerr++; end
      tick();
      set_src(0, 1'b1, 1'b1, 1'b0, 6'd0, mk(0, 0));
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      set_src(0, 1'b1, 1'b1, 1'b0, 6'd0, mk(0, 1));
      @(negedge clk);
      ncmp++; if (proto_err !== 1'b0) begin $display("FAIL pe_clean_first: got %b want 0", proto_err); nerr++; end
      ncmp++; if (out_data !== mk(0, 1)) begin $display("FAIL pe_fwd_dup: got %0h want %0h", out_data, mk(0, 1)); nerr++; end
      tick();
      set_src(0, 1'b1, 1'b0, 1'b1, 6'd0, mk(0, 2));
      @(negedge clk);
      ncmp++; if (proto_err !== 1'b1) begin $display("FAIL pe_dupsop: got %b want 1", proto_err); nerr++; end
      tick();
      clear_all();
      @(negedge clk);
      ncmp++; if (pkt_cnt !== 32'd1) begin $display("FAIL pe_pkt_cnt2: got %0d want 1", pkt_cnt); nerr++; end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_src(1, 1'b1, 1'b1, 1'b1, 6'd0, mk(1, 0));
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      clear_all();
      set_src(3, 1'b1, 1'b1, 1'b0, 6'd0, mk(3, 0));
      @(negedge clk);
      tick();
      @(negedge clk);
      ncmp++; if (out_src !== 2'd3) begin $display("FAIL rm_src: got %0d want 3", out_src); nerr++; end
      tick();
      set_src(3, 1'b1, 1'b0, 1'b0, 6'd0, mk(3, 1));
      @(negedge clk);
      ncmp++; if (pkt_cnt !== 32'd1) begin $display("FAIL rm_cnt_before: got %0d want 1", pkt_cnt); nerr++; end
      tick();
      rst = 1'b1;
      set_src(3, 1'b1, 1'b0, 1'b0, 6'd0, mk(3, 2));
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL rm_valid_in_rst: got %b want 0", out_valid); nerr++; end
      ncmp++; if (in_ready !== 4'b0000) begin $display("FAIL rm_ready_in_rst: got %b want 0000", in_ready); nerr++; end
      tick();
      rst = 1'b0;
      set_src(3, 1'b1, 1'b1, 1'b0, 6'd0, mk(3, 0));
      set_src(0, 1'b1, 1'b1, 1'b0, 6'd0, mk(0, 0));
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL rm_idle: got %b want 0", out_valid); nerr++; end
      ncmp++; if (pkt_cnt !== 32'd0) begin $display("FAIL rm_pkt_cnt: got %0d want 0", pkt_cnt); nerr++; end
      ncmp++; if (in_ready !== 4'b0000) begin $display("FAIL rm_ready_idle: got %b want 0000", in_ready); nerr++; end
      tick();
      @(negedge clk);
      ncmp++; if (out_src !== 2'd0) begin $display("FAIL rm_first_grant: got %0d want 0", out_src); nerr++; end
      ncmp++; if (in_ready !== 4'b0001) begin $display("FAIL rm_ready_grant: got %b want 0001", in_ready); nerr++; end
      ncmp++; if (out_data !== mk(0, 0)) begin $display("FAIL rm_data: got %0h want %0h", out_data, mk(0, 0)); nerr++; end
      tick();
      clear_all();
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_src(0, 1'b1, 1'b1, 1'b1, 6'd0, mk(0, 0));
      set_src(1, 1'b1, 1'b1, 1'b1, 6'd0, mk(1, 0));
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL b2b_bubble0: got %b want 0", out_valid); nerr++; end
      tick();
      @(negedge clk);
      ncmp++; if (out_src !== 2'd0) begin $display("FAIL b2b_src0: got %0d want 0", out_src); nerr++; end
      ncmp++; if ({out_valid, out_sop, out_eop} !== 3'b111) begin $display("FAIL b2b_flags0: got %b want 111", {out_valid, out_sop, out_eop}); nerr++; end
      ncmp++; if (out_data !== mk(0, 0)) begin $display("FAIL b2b_data0: got %0h want %0h", out_data, mk(0, 0)); nerr++; end
      tick();
      set_src(0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
      @(negedge clk);
      ncmp++; if (out_valid !== 1'b0) begin $display("FAIL b2b_bubble1: got %b want 0", out_valid); nerr++; end
      tick();
      @(negedge clk);
      ncmp++; if (out_src !== 2'd1) begin $display("FAIL b2b_src1: got %0d want 1", out_src); nerr++; end
      ncmp++; if ({out_valid, out_sop, out_eop} !== 3'b111) begin $display("FAIL b2b_flags1: got %b want 111", {out_valid, out_sop, out_eop}); nerr++; end
      ncmp++; if (out_data !== mk(1, 0)) begin $display("FAIL b2b_data1: got %0h want %0h", out_data, mk(1, 0)); nerr++; end
      tick();
      clear_all();
      @(negedge clk);
      ncmp++; if (pkt_cnt !== 32'd2) begin $display("FAIL b2b_pkt_cnt: got %0d want 2", pkt_cnt); nerr++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      clear_all();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_proto_err();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
